// File: rtl/simulador_reservatorio.sv
// Tank-level emulator that turns valve/irrigation commands into float-switch
// sensors for the irrigation controller, so the system runs with no hardware.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   VE, GT, AS       - inlet valve, drip irrigation, sprinkler (sampled on tick)
//   A, M, B          - thermometer-coded level sensors (high, mid, low)
//   nivel            - current level register
//   transbordo, seco - one-clock pulses when a tick's update is clipped
module simulador_reservatorio #(
    parameter int LEVEL_W    = 8,
    parameter int MAX_LEVEL  = 200,
    parameter int INIT_LEVEL = 0,
    parameter int B_TH       = 40,
    parameter int M_TH       = 100,
    parameter int A_TH       = 160,
    parameter int HYST       = 4,
    parameter int FILL_RATE  = 4,
    parameter int DRIP_RATE  = 1,
    parameter int SPRAY_RATE = 3,
    parameter int TICK_DIV   = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               VE,
    input  logic               GT,
    input  logic               AS,
    output logic               A,
    output logic               M,
    output logic               B,
    output logic [LEVEL_W-1:0] nivel,
    output logic               transbordo,
    output logic               seco
);

    localparam int CW = $clog2(TICK_DIV);
    // Three extra bits keep nivel + delta free of wrap in both directions.
    localparam int SW = LEVEL_W + 3;

    localparam logic signed [SW-1:0] FILL_S  = SW'(FILL_RATE);
    localparam logic signed [SW-1:0] DRIP_S  = SW'(DRIP_RATE);
    localparam logic signed [SW-1:0] SPRAY_S = SW'(SPRAY_RATE);
    localparam logic signed [SW-1:0] MAX_S   = SW'(MAX_LEVEL);

    localparam logic [LEVEL_W-1:0] B_UP = LEVEL_W'(B_TH);
    localparam logic [LEVEL_W-1:0] M_UP = LEVEL_W'(M_TH);
    localparam logic [LEVEL_W-1:0] A_UP = LEVEL_W'(A_TH);
    localparam logic [LEVEL_W-1:0] B_DN = LEVEL_W'(B_TH - HYST);
    localparam logic [LEVEL_W-1:0] M_DN = LEVEL_W'(M_TH - HYST);
    localparam logic [LEVEL_W-1:0] A_DN = LEVEL_W'(A_TH - HYST);

    typedef enum logic [1:0] {
        VAZIO = 2'd0,
        BAIXO = 2'd1,
        MEDIO = 2'd2,
        ALTO  = 2'd3
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   tick;
    logic signed [SW-1:0]   delta;
    logic signed [SW-1:0]   nxt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_comb begin
        delta = '0;
        if (VE) delta = delta + FILL_S;
        if (GT) delta = delta - DRIP_S;
        if (AS) delta = delta - SPRAY_S;
        nxt = $signed({3'b000, nivel}) + delta;
    end

    // Prescaler and level integrator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            nivel      <= LEVEL_W'(INIT_LEVEL);
            transbordo <= 1'b0;
            seco       <= 1'b0;
        end else begin
            transbordo <= 1'b0;
            seco       <= 1'b0;
            cnt        <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                if (nxt > MAX_S) begin
                    nivel      <= LEVEL_W'(MAX_LEVEL);
                    transbordo <= (delta > 0);
                end else if (nxt < 0) begin
                    nivel <= '0;
                    seco  <= (delta < 0);
                end else begin
                    nivel <= nxt[LEVEL_W-1:0];
                end
            end
        end
    end

    // Sensor FSM: one step per clock, outputs registered with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= VAZIO;
            {A, M, B} <= 3'b000;
        end else begin
            unique case (state)
                VAZIO: begin
                    if (nivel >= B_UP) begin
                        state     <= BAIXO;
                        {A, M, B} <= 3'b001;
                    end
                end
                BAIXO: begin
                    if (nivel >= M_UP) begin
                        state     <= MEDIO;
                        {A, M, B} <= 3'b011;
                    end else if (nivel < B_DN) begin
                        state     <= VAZIO;
                        {A, M, B} <= 3'b000;
                    end
                end
                MEDIO: begin
                    if (nivel >= A_UP) begin
                        state     <= ALTO;
                        {A, M, B} <= 3'b111;
                    end else if (nivel < M_DN) begin
                        state     <= BAIXO;
                        {A, M, B} <= 3'b001;
                    end
                end
                ALTO: begin
                    if (nivel < A_DN) begin
                        state     <= MEDIO;
                        {A, M, B} <= 3'b011;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simulador_reservatorio.sv
// Bench for simulador_reservatorio: two instances (INIT_LEVEL 0 and 180),
// an integer reference model, per-cycle compare and directed literal checks.
module tb_simulador_reservatorio;

    localparam int TD   = 4;
    localparam int MAXL = 200;
    localparam int HY   = 4;

    logic clk = 1'b0;
    logic rst_n, VE, GT, AS;
    logic a0, m0, b0, tr0, se0;
    logic a1, m1, b1, tr1, se1;
    logic [7:0] lvl0, lvl1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    simulador_reservatorio #(.TICK_DIV(TD)) u0 (
        .clk(clk), .rst_n(rst_n), .VE(VE), .GT(GT), .AS(AS),
        .A(a0), .M(m0), .B(b0), .nivel(lvl0),
        .transbordo(tr0), .seco(se0)
    );

    simulador_reservatorio #(.TICK_DIV(TD), .INIT_LEVEL(180)) u1 (
        .clk(clk), .rst_n(rst_n), .VE(VE), .GT(GT), .AS(AS),
        .A(a1), .M(m1), .B(b1), .nivel(lvl1),
        .transbordo(tr1), .seco(se1)
    );

    // Reference model: level as an integer, sensors as a count of lit
    // switches (0..3) that moves one step per clock toward the level.
    int m_lvl [2] = '{0, 180};
    int m_k   [2] = '{0, 0};
    bit m_tr  [2] = '{0, 0};
    bit m_se  [2] = '{0, 0};
    int m_cnt = 0;

    function automatic int up_th(input int k);
        return (k == 0) ? 40 : (k == 1) ? 100 : 160;
    endfunction

    always @(posedge clk) begin
        int d, nx;
        bit t;
        if (!rst_n) begin
            m_cnt = 0;
            m_lvl[0] = 0;
            m_lvl[1] = 180;
            for (int i = 0; i < 2; i++) begin
                m_k[i] = 0;
                m_tr[i] = 0;
                m_se[i] = 0;
            end
        end else begin
            t = (m_cnt == TD - 1);
            m_cnt = t ? 0 : m_cnt + 1;
            d = (VE ? 4 : 0) - (GT ? 1 : 0) - (AS ? 3 : 0);
            for (int i = 0; i < 2; i++) begin
                if (m_k[i] < 3 && m_lvl[i] >= up_th(m_k[i]))
                    m_k[i] = m_k[i] + 1;
                else if (m_k[i] > 0 && m_lvl[i] < up_th(m_k[i] - 1) - HY)
                    m_k[i] = m_k[i] - 1;
                m_tr[i] = 0;
                m_se[i] = 0;
                if (t) begin
                    nx = m_lvl[i] + d;
                    if (nx > MAXL) begin
                        m_lvl[i] = MAXL;
                        m_tr[i] = (d > 0);
                    end else if (nx < 0) begin
                        m_lvl[i] = 0;
                        m_se[i] = (d < 0);
                    end else begin
                        m_lvl[i] = nx;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic wait_lvl(input int v, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (int'(lvl0) == v) return;
            @(negedge clk);
        end
        chk($sformatf("timeout waiting nivel=%0d", v), int'(lvl0), v);
    endtask

    task automatic count_pulses(input bit use_tr, output int n);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += use_tr ? int'(tr0) : int'(se0);
        end
    endtask

    task automatic step(input bit ve, input bit gt, input bit as_);
        VE = ve;
        GT = gt;
        AS = as_;
        repeat (TD) @(negedge clk);
    endtask

    task automatic stimulus();
        int n;
        rst_n = 1'b0;
        VE = 1'b1;
        GT = 1'b0;
        AS = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset nivel0", int'(lvl0), 0);
        chk("reset nivel1", int'(lvl1), 180);
        chk("reset AMB1", int'({a1, m1, b1}), 0);
        chk("reset flags0", int'({tr0, se0}), 0);

        rst_n = 1'b1;
        @(negedge clk) chk("init180 step1", int'({a1, m1, b1}), 1);
        @(negedge clk) chk("init180 step2", int'({a1, m1, b1}), 3);
        @(negedge clk) chk("init180 step3", int'({a1, m1, b1}), 7);
        chk("no tick before TICK_DIV", int'(lvl0), 0);
        @(negedge clk) chk("first tick", int'(lvl0), 4);

        wait_lvl(40, 400);
        chk("B at 40 same clk", int'(b0), 0);
        @(negedge clk) chk("B rises", int'(b0), 1);
        wait_lvl(100, 400);
        chk("M at 100 same clk", int'(m0), 0);
        @(negedge clk) chk("M rises", int'(m0), 1);
        wait_lvl(160, 400);
        chk("A at 160 same clk", int'(a0), 0);
        @(negedge clk) chk("A rises", int'(a0), 1);

        wait_lvl(200, 400);
        chk("no overflow on exact 200", int'(tr0), 0);
        count_pulses(1'b1, n);
        chk("overflow pulses 5 ticks", n, 5);
        chk("saturated nivel", int'(lvl0), 200);

        VE = 1'b0;
        AS = 1'b1;
        wait_lvl(155, 400);
        chk("A held at 155", int'(a0), 1);
        @(negedge clk) chk("A drops", int'(a0), 0);
        wait_lvl(95, 400);
        chk("M held at 95", int'(m0), 1);
        @(negedge clk) chk("M drops", int'(m0), 0);
        wait_lvl(35, 400);
        chk("B held at 35", int'(b0), 1);
        @(negedge clk) chk("B drops", int'(b0), 0);
        wait_lvl(0, 400);
        chk("seco on clip to 0", int'(se0), 1);
        count_pulses(1'b0, n);
        chk("seco pulses 5 ticks", n, 5);
        chk("empty nivel", int'(lvl0), 0);

        VE = 1'b1;
        AS = 1'b0;
        wait_lvl(100, 400);
        repeat (3) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b1, 1'b1, 1'b0);
        end
        chk("hyst nivel", int'(lvl0), 100);
        chk("hyst M held", int'(m0), 1);
        step(1'b0, 1'b0, 1'b1);
        chk("hyst M held at 97", int'(m0), 1);
        step(1'b0, 1'b0, 1'b1);
        chk("hyst nivel 94", int'(lvl0), 94);
        @(negedge clk) chk("hyst M clears", int'(m0), 0);

        VE = 1'b1;
        AS = 1'b0;
        wait_lvl(200, 400);
        {VE, GT, AS} = 3'b111;
        count_pulses(1'b1, n);
        chk("delta0 no overflow", n, 0);
        chk("delta0 nivel 200", int'(lvl0), 200);
        {VE, GT, AS} = 3'b001;
        wait_lvl(0, 400);
        {VE, GT, AS} = 3'b111;
        count_pulses(1'b0, n);
        chk("delta0 no seco", n, 0);
        chk("delta0 nivel 0", int'(lvl0), 0);

        {VE, GT, AS} = 3'b000;
        @(negedge clk) VE = 1'b1;
        @(negedge clk) VE = 1'b0;
        repeat (4) @(negedge clk);
        chk("off-tick input ignored", int'(lvl0), 0);

        VE = 1'b1;
        wait_lvl(120, 400);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        chk("mid reset nivel0", int'(lvl0), 0);
        chk("mid reset nivel1", int'(lvl1), 180);
        chk("mid reset AMB0", int'({a0, m0, b0}), 0);
        chk("mid reset AMB1", int'({a1, m1, b1}), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("prescaler restart", int'(lvl0), 0);
        @(negedge clk);
        chk("restart first tick0", int'(lvl0), 4);
        chk("restart first tick1", int'(lvl1), 184);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    chk("nivel0", int'(lvl0), m_lvl[0]);
                    chk("nivel1", int'(lvl1), m_lvl[1]);
                    chk("A0", int'(a0), int'(m_k[0] == 3));
                    chk("M0", int'(m0), int'(m_k[0] >= 2));
                    chk("B0", int'(b0), int'(m_k[0] >= 1));
                    chk("A1", int'(a1), int'(m_k[1] == 3));
                    chk("M1", int'(m1), int'(m_k[1] >= 2));
                    chk("B1", int'(b1), int'(m_k[1] >= 1));
                    chk("transbordo0", int'(tr0), int'(m_tr[0]));
                    chk("seco0", int'(se0), int'(m_se[0]));
                    chk("transbordo1", int'(tr1), int'(m_tr[1]));
                    chk("seco1", int'(se1), int'(m_se[1]));
                end
            end
            stimulus();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
